// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle control FSM and the datapath.
// The controller owns the master modport; the datapath (or a bench) uses slave.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  // Instruction fields and ALU status coming from the datapath
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic             zero;

  // Datapath enables, mux selects and ALU operation
  logic             PCWrite;
  logic             AdrSrc;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALUControl;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, funct3, funct7b5, zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ALUControl, illegal, instret
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ALUControl, illegal, instret
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM (lw, sw, R/I ALU, jal, beq, bne) with a
// retired-instruction counter. Outputs are decoded from the state register.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master ctl
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BRANCH   = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_BAD = 3'b111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  state_t           state_reg;
  state_t           state_next;
  state_t           dec_state;
  logic [CNT_W-1:0] instret_reg;
  logic [CNT_W-1:0] instret_next;
  logic             retire;

  logic             pc_write;
  logic             adr_src;
  logic             mem_write;
  logic             ir_write;
  logic             reg_write;
  logic [1:0]       result_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_control;
  logic             illegal;

  logic [2:0]       funct_alu;
  logic             funct_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= FETCH;
      instret_reg <= '0;
    end else begin
      state_reg   <= state_next;
      instret_reg <= instret_next;
    end
  end

  // ALU operation for R/I arithmetic; only R-type uses funct7b5 to pick sub.
  always_comb begin
    funct_alu = ALU_BAD;
    funct_bad = 1'b0;
    case (ctl.funct3)
      3'b000:  funct_alu = ((state_reg == EXEC_R) && ctl.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_alu = ALU_SLT;
      3'b100:  funct_alu = ALU_XOR;
      3'b110:  funct_alu = ALU_OR;
      3'b111:  funct_alu = ALU_AND;
      default: begin
        funct_alu = ALU_BAD;
        funct_bad = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_next  = FETCH;
    retire      = 1'b0;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    illegal     = 1'b0;

    // While in reset the selects look like FETCH; enables are masked below.
    dec_state = reset ? FETCH : state_reg;

    case (dec_state)
      FETCH: begin
        adr_src     = 1'b0;
        ir_write    = 1'b1;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_FOUR;
        alu_control = ALU_ADD;
        result_src  = RES_ALURES;
        pc_write    = 1'b1;
        state_next  = DECODE;
      end
      DECODE: begin
        alu_src_a   = SRCA_OLDPC;
        alu_src_b   = SRCB_IMM;
        alu_control = ALU_ADD;
        case (ctl.op)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_R:              state_next = EXEC_R;
          OP_I:              state_next = EXEC_I;
          OP_JAL:            state_next = JAL;
          OP_BRANCH:         state_next = BRANCH;
          default: begin
            state_next = FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        alu_control = ALU_ADD;
        state_next  = ctl.op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        result_src = RES_RDATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      EXEC_R: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_RS2;
        alu_control = funct_alu;
        illegal     = funct_bad;
        state_next  = ALUWB;
      end
      EXEC_I: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        alu_control = funct_alu;
        illegal     = funct_bad;
        state_next  = ALUWB;
      end
      ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        alu_src_a   = SRCA_OLDPC;
        alu_src_b   = SRCB_FOUR;
        alu_control = ALU_ADD;
        result_src  = RES_ALUOUT;
        pc_write    = 1'b1;
        state_next  = ALUWB;
      end
      BRANCH: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_RS2;
        alu_control = ALU_SUB;
        result_src  = RES_ALUOUT;
        retire      = 1'b1;
        state_next  = FETCH;
        case (ctl.funct3)
          3'b000:  pc_write = ctl.zero;
          3'b001:  pc_write = ~ctl.zero;
          default: illegal  = 1'b1;
        endcase
      end
      default: begin
        state_next = FETCH;
      end
    endcase

    if (reset) begin
      pc_write   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;
      retire     = 1'b0;
      state_next = FETCH;
    end
  end

  // Free-running wrap at 2^CNT_W.
  assign instret_next = instret_reg + (retire ? CNT_W'(1) : CNT_W'(0));

  assign ctl.PCWrite    = pc_write;
  assign ctl.AdrSrc     = adr_src;
  assign ctl.MemWrite   = mem_write;
  assign ctl.IRWrite    = ir_write;
  assign ctl.RegWrite   = reg_write;
  assign ctl.ResultSrc  = result_src;
  assign ctl.ALUSrcA    = alu_src_a;
  assign ctl.ALUSrcB    = alu_src_b;
  assign ctl.ALUControl = alu_control;
  assign ctl.illegal    = illegal;
  assign ctl.instret    = instret_reg;

endmodule
